fifox_rd_arbiter: RTL and testbench
===================================

Name: fifox_rd_arbiter

Overview:
N-to-1 read scheduler that drains several FIFOX output ports into one registered output stream with valid/ready handshake. FIFOX outputs are first-word-fall-through: DO is valid while EMPTY=0, and RD pops that word. The block sits behind a bank of per-source FIFOX instances, for example per-channel buffers in front of a shared DMA or MAC lane. It issues RD to exactly one FIFO per cycle, using round-robin with bounded bursts.

Parameters:
FIFO_COUNT, 4, number of FIFOX sources (>=2).
ITEM_WIDTH, 8, width of each FIFO item.
MAX_BURST, 4, max consecutive pops from one source before forced re-arbitration (>=1; 1 = pure round-robin).

Ports:
CLK  in  1  clock.
RESET  in  1  asynchronous reset, active-high.
FIFO_DO  in  FIFO_COUNT*ITEM_WIDTH  packed DO of each FIFOX; source i at bits [i*ITEM_WIDTH +: ITEM_WIDTH].
FIFO_EMPTY  in  FIFO_COUNT  EMPTY of each FIFOX.
FIFO_AEMPTY  in  FIFO_COUNT  AEMPTY of each FIFOX (used only with optional feature).
FIFO_RD  out  FIFO_COUNT  one-hot-or-zero read strobe per FIFOX.
TX_DATA  out  ITEM_WIDTH  output item.
TX_SRC  out  log2(FIFO_COUNT)  index of source FIFO of TX_DATA.
TX_VLD  out  1  TX_DATA/TX_SRC valid.
TX_DST_RDY  in  1  sink accepts item when TX_VLD=1.

Behaviour:
- One clock, CLK; RESET is asynchronous, active-high.
- Reset values: TX_VLD=0, TX_DATA=0, TX_SRC=0, internal last-grant pointer=FIFO_COUNT-1 (so first pick is source 0), burst counter=0, state=IDLE. FIFO_RD is combinational; it is 0 while RESET=1.
- Output stage is one register. Pop enable: POP = (any eligible source) && (!TX_VLD || TX_DST_RDY).
- FIFO_RD[g] = POP for granted index g; all other bits 0. FIFO_RD is never asserted to a FIFO with EMPTY=1.
- Latency: the word popped in cycle t appears on TX_DATA with TX_VLD=1 in cycle t+1, with TX_SRC=g.
- Without a pop: if TX_DST_RDY=1, TX_VLD goes to 0; otherwise TX_DATA, TX_SRC and TX_VLD hold.
- State machine IDLE/BURST:
  - IDLE: grant is the first non-empty source scanning from last+1 with wrap-around. On POP, go to BURST, set cur=g, set cnt=1.
  - BURST: if !EMPTY[cur] and cnt<MAX_BURST, grant=cur; a POP increments cnt.
  - BURST, otherwise: re-arbitrate round-robin starting from cur+1, excluding cur unless cur is the only non-empty source. In that case cur is re-granted and cnt resets to 1. A POP loads the new cur with cnt=1; with no POP, go to IDLE.
  - last is updated to g on every POP.
- Backpressure (TX_VLD=1, TX_DST_RDY=0): no RD, state/cnt/cur frozen.
- All FIFOs empty: no RD; state returns to IDLE; TX drains normally.
- FIFO empties mid-burst: switch to the next source in the same cycle; no bubble if another source is non-empty.
- MAX_BURST=1: strict round-robin, one item per source per turn.
- Reset mid-operation: TX register content is discarded (item already popped is lost); FIFOs are not re-read.
- Counter width: clog2(MAX_BURST+1); it never exceeds MAX_BURST.

Optional Feature:
Macro FIFOX_RD_ARBITER_AEMPTY_PRIO_EN.
- Defined: round-robin candidates with AEMPTY=0 take priority over those with AEMPTY=1. An AEMPTY=1 non-empty source is granted only when no non-empty AEMPTY=0 source exists. A burst on a source ends early when its AEMPTY rises and another source with AEMPTY=0 is non-empty.
- Undefined: FIFO_AEMPTY is ignored (unused input); pure round-robin as above.

Decomposition:
- Package fifox_rd_arbiter_pkg: state enum (IDLE, BURST), function clog2-based width constants, and function rr_pick(req vector, start index) returning found flag plus index.
- One sub-module, fifox_rr_pick: combinational round-robin priority encoder (req, start -> vld, idx). It is instantiated once; with the feature on, it is instantiated twice (high-priority and fallback masks).

Test Plan:
- Reset, all EMPTY=1 -> FIFO_RD=0, TX_VLD=0 indefinitely.
- MAX_BURST=4, FIFOs 0..3 each hold 6 items, TX_DST_RDY=1 -> TX_SRC sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,0,1,1,2,2,3,3; one item per cycle, no bubbles.
- Only FIFO 2 non-empty with 10 items -> 10 consecutive pops from 2; cnt re-arms after 4; TX_SRC=2 throughout.
- TX_DST_RDY=0 for 5 cycles while TX_VLD=1 -> FIFO_RD=0 and TX_DATA stable; on release, next item one cycle later, order preserved.
- FIFO 1 empties after 2 items in a burst with FIFO 3 non-empty -> next cycle FIFO_RD[3]=1, no gap.
- Feature on: FIFO 0 AEMPTY=1 with 1 item, FIFO 1 AEMPTY=0 with 8 items -> FIFO 1 served first; FIFO 0 read only after FIFO 1 empties or asserts AEMPTY.

Source files
------------

// File: rtl/fifox_rd_arbiter_pkg.sv
// Shared types and helpers for the FIFOX read arbiter: FSM states, width helpers and the
// round-robin search used by fifox_rr_pick.
package fifox_rd_arbiter_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } state_e;

    // Upper bound on sources the generic search supports.
    localparam int unsigned MaxFifos = 64;
    localparam int unsigned MaxIdxW  = 6;

    typedef struct packed {
        logic               vld;
        logic [MaxIdxW-1:0] idx;
    } rr_res_t;

    function automatic int unsigned idx_width(int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned cnt_width(int unsigned max_burst);
        return $clog2(max_burst + 1);
    endfunction

    // First set bit of req[n-1:0], scanning upward from start with wrap-around.
    function automatic rr_res_t rr_pick(logic [MaxFifos-1:0] req, int unsigned start,
                                        int unsigned n);
        rr_res_t     res;
        int unsigned i;
        res = '0;
        for (int unsigned k = 0; k < MaxFifos; k++) begin
            if (k < n) begin
                i = start + k;
                if (i >= n) begin
                    i = i - n;
                end
                if (!res.vld && req[i[MaxIdxW-1:0]]) begin
                    res.vld = 1'b1;
                    res.idx = i[MaxIdxW-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fifox_rr_pick.sv
// Combinational round-robin priority encoder: first requester at or after start_i, wrapping.
module fifox_rr_pick
    import fifox_rd_arbiter_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] start_i,
    output logic            vld_o,
    output logic [IdxW-1:0] idx_o
);

    logic [MaxFifos-1:0] req_ext;
    rr_res_t             res;
    logic                unused_idx;

    assign req_ext    = MaxFifos'(req_i);
    assign res        = rr_pick(req_ext, 32'(start_i), N);
    assign vld_o      = res.vld;
    assign idx_o      = res.idx[IdxW-1:0];
    assign unused_idx = ^res.idx;

endmodule

// File: rtl/fifox_rd_arbiter.sv
// N-to-1 bounded-burst round-robin scheduler draining FWFT FIFOX ports into a registered stream.
// Define FIFOX_RD_ARBITER_AEMPTY_PRIO_EN to favour sources whose AEMPTY is low.
module fifox_rd_arbiter
    import fifox_rd_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_COUNT = 4,
    parameter int unsigned ITEM_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic [FIFO_COUNT*ITEM_WIDTH-1:0] FIFO_DO,
    input  logic [FIFO_COUNT-1:0]            FIFO_EMPTY,
    input  logic [FIFO_COUNT-1:0]            FIFO_AEMPTY,
    output logic [FIFO_COUNT-1:0]            FIFO_RD,
    output logic [ITEM_WIDTH-1:0]            TX_DATA,
    output logic [idx_width(FIFO_COUNT)-1:0] TX_SRC,
    output logic                             TX_VLD,
    input  logic                             TX_DST_RDY
);

    localparam int unsigned IdxW = idx_width(FIFO_COUNT);
    localparam int unsigned CntW = cnt_width(MAX_BURST);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_BURST);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(FIFO_COUNT - 1);

    state_e                state_q, state_d;
    logic [IdxW-1:0]       cur_q, cur_d;
    logic [IdxW-1:0]       last_q, last_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  tx_vld_q, tx_vld_d;
    logic [ITEM_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [IdxW-1:0]       tx_src_q, tx_src_d;

    logic [ITEM_WIDTH-1:0] fifo_do_arr [FIFO_COUNT];
    logic [FIFO_COUNT-1:0] nonempty;
    logic [IdxW-1:0]       base_idx, start_idx, grant;
    logic                  pick_vld, yield, continue_burst, can_pop, pop;
    logic [IdxW-1:0]       pick_idx;

    for (genvar i = 0; i < FIFO_COUNT; i++) begin : g_unpack
        assign fifo_do_arr[i] = FIFO_DO[i*ITEM_WIDTH +: ITEM_WIDTH];
    end

    assign nonempty  = ~FIFO_EMPTY;
    // In a burst last == cur, so one start point serves both IDLE and re-arbitration; the
    // current owner comes last in the scan and so only wins when it is alone.
    assign base_idx  = (state_q == StBurst) ? cur_q : last_q;
    assign start_idx = (base_idx == LastIdx) ? '0 : base_idx + IdxW'(1);

`ifdef FIFOX_RD_ARBITER_AEMPTY_PRIO_EN
    logic            hi_vld, lo_vld;
    logic [IdxW-1:0] hi_idx, lo_idx;

    fifox_rr_pick #(
        .N    (FIFO_COUNT),
        .IdxW (IdxW)
    ) u_pick_hi (
        .req_i   (nonempty & ~FIFO_AEMPTY),
        .start_i (start_idx),
        .vld_o   (hi_vld),
        .idx_o   (hi_idx)
    );

    fifox_rr_pick #(
        .N    (FIFO_COUNT),
        .IdxW (IdxW)
    ) u_pick_lo (
        .req_i   (nonempty),
        .start_i (start_idx),
        .vld_o   (lo_vld),
        .idx_o   (lo_idx)
    );

    assign pick_vld = hi_vld | lo_vld;
    assign pick_idx = hi_vld ? hi_idx : lo_idx;
    // cur is excluded from the high mask while AEMPTY, so hi_vld means another healthy source.
    assign yield    = FIFO_AEMPTY[cur_q] & hi_vld;
`else
    logic unused_aempty;

    fifox_rr_pick #(
        .N    (FIFO_COUNT),
        .IdxW (IdxW)
    ) u_pick (
        .req_i   (nonempty),
        .start_i (start_idx),
        .vld_o   (pick_vld),
        .idx_o   (pick_idx)
    );

    assign yield         = 1'b0;
    assign unused_aempty = ^FIFO_AEMPTY;
`endif

    assign continue_burst = (state_q == StBurst) && nonempty[cur_q] && (cnt_q < MaxCnt) && !yield;
    assign grant          = continue_burst ? cur_q : pick_idx;
    assign can_pop        = !tx_vld_q || TX_DST_RDY;
    assign pop            = (continue_burst || pick_vld) && can_pop && !RESET;
    assign FIFO_RD        = pop ? (FIFO_COUNT'(1) << grant) : '0;

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        tx_vld_d  = tx_vld_q;
        tx_data_d = tx_data_q;
        tx_src_d  = tx_src_q;
        if (pop) begin
            tx_vld_d  = 1'b1;
            tx_data_d = fifo_do_arr[grant];
            tx_src_d  = grant;
            last_d    = grant;
            state_d   = StBurst;
            if (continue_burst) begin
                cnt_d = cnt_q + CntW'(1);
            end else begin
                cur_d = grant;
                cnt_d = CntW'(1);
            end
        end else begin
            if (TX_DST_RDY) begin
                tx_vld_d = 1'b0;
            end
            // Free to pop yet nothing popped: every source is empty.
            if (can_pop) begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= StIdle;
            cur_q     <= '0;
            last_q    <= LastIdx;
            cnt_q     <= '0;
            tx_vld_q  <= 1'b0;
            tx_data_q <= '0;
            tx_src_q  <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            tx_vld_q  <= tx_vld_d;
            tx_data_q <= tx_data_d;
            tx_src_q  <= tx_src_d;
        end
    end

    assign TX_VLD  = tx_vld_q;
    assign TX_DATA = tx_data_q;
    assign TX_SRC  = tx_src_q;

endmodule

// File: tb/tb_fifox_rd_arbiter.sv
// Bench for fifox_rd_arbiter: queue-based FIFO models, a rule-level scheduler model,
// directed scenarios and a randomized run with backpressure and a mid-run reset.
module tb_fifox_rd_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;
`ifdef FIFOX_RD_ARBITER_AEMPTY_PRIO_EN
    localparam bit PrioOn = 1'b1;
`else
    localparam bit PrioOn = 1'b0;
`endif

    logic         CLK;
    logic         RESET;
    logic [N*W-1:0] FIFO_DO;
    logic [N-1:0] FIFO_EMPTY;
    logic [N-1:0] FIFO_AEMPTY;
    logic [N-1:0] FIFO_RD;
    logic [W-1:0] TX_DATA;
    logic [1:0]   TX_SRC;
    logic         TX_VLD;
    logic         TX_DST_RDY;

    fifox_rd_arbiter #(
        .FIFO_COUNT (N),
        .ITEM_WIDTH (W),
        .MAX_BURST  (MB)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .FIFO_DO     (FIFO_DO),
        .FIFO_EMPTY  (FIFO_EMPTY),
        .FIFO_AEMPTY (FIFO_AEMPTY),
        .FIFO_RD     (FIFO_RD),
        .TX_DATA     (TX_DATA),
        .TX_SRC      (TX_SRC),
        .TX_VLD      (TX_VLD),
        .TX_DST_RDY  (TX_DST_RDY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // FIFO contents and stimulus knobs
    logic [W-1:0] q [N][$];
    int           aempty_mode = 0;
    logic [N-1:0] aempty_set  = '0;
    bit           rdy         = 1'b1;
    bit           rst_req     = 1'b1;

    // Scheduler model: who owns the burst, how many it has had, who was served last
    bit           m_burst;
    int           m_owner, m_served, m_last;
    bit           m_vld;
    logic [W-1:0] m_data;
    int           m_src;

    int           cap_src[$];
    logic [W-1:0] cap_data[$];
    int           cap_cyc[$];
    int           cyc = 0;
    logic [W-1:0] tag_ctr = 8'd0;

    task automatic model_reset();
        m_burst  = 1'b0;
        m_owner  = 0;
        m_served = 0;
        m_last   = N - 1;
        m_vld    = 1'b0;
        m_data   = '0;
        m_src    = 0;
    endtask

    function automatic int model_pick(input int after);
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (after + k) % N;
                if (q[i].size() > 0 && (pass == 1 || !PrioOn || !FIFO_AEMPTY[i])) return i;
            end
        end
        return -1;
    endfunction

    task automatic model_grant(output int g, output bit keep);
        keep = m_burst && q[m_owner].size() > 0 && m_served < MB;
        if (keep && PrioOn && FIFO_AEMPTY[m_owner]) begin
            for (int j = 0; j < N; j++) begin
                if (j != m_owner && q[j].size() > 0 && !FIFO_AEMPTY[j]) keep = 1'b0;
            end
        end
        g = keep ? m_owner : model_pick(m_burst ? m_owner : m_last);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            FIFO_EMPTY[i]     = (q[i].size() == 0);
            FIFO_DO[i*W +: W] = (q[i].size() > 0) ? q[i][0] : 8'hEE;
            case (aempty_mode)
                0:       FIFO_AEMPTY[i] = 1'b0;
                1:       FIFO_AEMPTY[i] = (q[i].size() <= 2);
                default: FIFO_AEMPTY[i] = aempty_set[i];
            endcase
        end
        TX_DST_RDY = rdy;
        RESET      = rst_req;
    endtask

    task automatic step();
        int           g;
        bit           keep;
        bit           pop;
        bit           can;
        logic [N-1:0] exp_rd;
        @(negedge CLK);
        drive();
        #1;
        if (RESET) begin
            model_reset();
            g    = -1;
            keep = 1'b0;
        end else begin
            model_grant(g, keep);
        end
        can    = !m_vld || rdy;
        pop    = !RESET && g >= 0 && can;
        exp_rd = pop ? (N'(1) << g) : '0;
        check_eq("fifo_rd", FIFO_RD, exp_rd);
        check_eq("tx_vld", TX_VLD, m_vld);
        if (m_vld || RESET) begin
            check_eq("tx_data", TX_DATA, m_data);
            check_eq("tx_src", TX_SRC, m_src);
        end
        if (TX_VLD && rdy && !RESET) begin
            cap_src.push_back(int'(TX_SRC));
            cap_data.push_back(TX_DATA);
            cap_cyc.push_back(cyc);
        end
        @(posedge CLK);
        cyc++;
        if (!RESET) begin
            if (pop) begin
                m_data = q[g].pop_front();
                m_src  = g;
                m_vld  = 1'b1;
                m_last = g;
                if (keep) begin
                    m_served++;
                end else begin
                    m_owner  = g;
                    m_served = 1;
                end
                m_burst = 1'b1;
            end else begin
                if (rdy) m_vld = 1'b0;
                if (can) m_burst = 1'b0;
            end
        end
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) return 1'b0;
        end
        return !m_vld;
    endfunction

    task automatic drain(input string tag);
        rdy = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (all_idle()) break;
            step();
        end
        check_eq(tag, 32'(all_idle()), 32'd1);
    endtask

    task automatic clear_caps();
        cap_src.delete();
        cap_data.delete();
        cap_cyc.delete();
    endtask

    initial begin
        int exp_seq[$];
        RESET      = 1'b1;
        TX_DST_RDY = 1'b1;
        FIFO_DO    = '0;
        FIFO_EMPTY = '1;
        FIFO_AEMPTY = '0;
        model_reset();

        // Reset held, then idle with everything empty
        rst_req = 1'b1;
        for (int c = 0; c < 3; c++) step();
        rst_req = 1'b0;
        for (int c = 0; c < 6; c++) step();

        // Four sources with six items each
        clear_caps();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < 6; k++) q[i].push_back(W'(i * 16 + k));
        end
        drain("drain_rr");
        for (int s = 0; s < N; s++) for (int b = 0; b < 4; b++) exp_seq.push_back(s);
        for (int s = 0; s < N; s++) for (int b = 0; b < 2; b++) exp_seq.push_back(s);
        check_eq("rr_len", cap_src.size(), exp_seq.size());
        if (cap_src.size() == exp_seq.size()) begin
            for (int k = 0; k < exp_seq.size(); k++) check_eq("rr_seq", cap_src[k], exp_seq[k]);
            check_eq("rr_no_bubble", cap_cyc[23] - cap_cyc[0], 23);
        end

        // Lone source longer than a burst
        clear_caps();
        for (int k = 0; k < 10; k++) q[2].push_back(W'(8'hA0 + k));
        drain("drain_lone");
        check_eq("lone_len", cap_src.size(), 10);
        for (int k = 0; k < cap_src.size(); k++) begin
            check_eq("lone_src", cap_src[k], 2);
            check_eq("lone_data", cap_data[k], W'(8'hA0 + k));
        end
        if (cap_cyc.size() == 10) check_eq("lone_no_bubble", cap_cyc[9] - cap_cyc[0], 9);

        // Backpressure for five cycles with TX valid
        clear_caps();
        for (int k = 0; k < 3; k++) q[1].push_back(W'(8'h50 + k));
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        for (int c = 0; c < 5; c++) step();
        drain("drain_bp");
        check_eq("bp_len", cap_src.size(), 3);
        for (int k = 0; k < cap_data.size(); k++) check_eq("bp_order", cap_data[k], W'(8'h50 + k));

`ifdef FIFOX_RD_ARBITER_AEMPTY_PRIO_EN
        // Almost-empty source waits for the healthy one
        clear_caps();
        aempty_mode = 2;
        aempty_set  = 4'b0001;
        q[0].push_back(8'h0F);
        for (int k = 0; k < 8; k++) q[1].push_back(W'(8'h10 + k));
        drain("drain_prio");
        check_eq("prio_len", cap_src.size(), 9);
        if (cap_src.size() == 9) begin
            for (int k = 0; k < 8; k++) check_eq("prio_src1", cap_src[k], 1);
            check_eq("prio_src0", cap_src[8], 0);
        end
        aempty_mode = 0;
`endif

        // Randomized traffic, backpressure and one asynchronous reset mid-stream
        aempty_mode = 1;
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                int f;
                f = $urandom_range(0, N - 1);
                if ($urandom_range(0, 99) < 35 && q[f].size() < 12) begin
                    q[f].push_back(tag_ctr);
                    tag_ctr++;
                end
            end
            rdy     = ($urandom_range(0, 3) != 0);
            rst_req = (c == 300);
            step();
        end
        rst_req = 1'b0;
        drain("drain_rand");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
